trace_capture_buffer: RTL

- Parametrised on-chip trace recorder for the single-cycle RISC-V core; successor to the bench-level probe/trace dump.
- Samples execute/writeback probe records (PC, ALU result, branch-taken, register-write info) into a circular buffer while armed.
- Freezes a configurable number of cycles after a trigger, then drains oldest-first over a valid/ready port.
- Instantiated beside design_wrapper; usable in simulation and on FPGA, where no $dumpvars is available.

---
 rtl/trace_capture_buffer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: on-chip recorder for execute/writeback probe records.
// Captures into a DEPTH-entry circular buffer while armed, keeps POST_SAMPLES more
// samples after the trigger, then drains oldest-first over a registered valid/ready port.
// Optional per-record timestamps are enabled by defining TRACE_TIMESTAMP_EN.
module trace_capture_buffer #(
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned POST_SAMPLES = 4,
    parameter int unsigned TS_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic                    sample_valid_i,
    input  logic [AWIDTH-1:0]       pc_i,
    input  logic [DWIDTH-1:0]       res_i,
    input  logic                    br_taken_i,
    input  logic                    rd_we_i,
    input  logic [4:0]              rd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [AWIDTH-1:0]       out_pc_o,
    output logic [DWIDTH-1:0]       out_res_o,
    output logic [6:0]              out_flags_o,
    output logic [TS_WIDTH-1:0]     out_ts_o,
    output logic [2:0]              state_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StPost  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   post_q, post_d;
    logic            overflow_q, overflow_d;
    logic            out_valid_q, out_valid_d;
    logic            store;
    logic            load_out;
    logic [PW-1:0]   rd_next;
    logic [PW-1:0]   rd_sel;

    logic [AWIDTH-1:0] pc_mem    [DEPTH];
    logic [DWIDTH-1:0] res_mem   [DEPTH];
    logic [6:0]        flags_mem [DEPTH];

    logic [AWIDTH-1:0] out_pc_q;
    logic [DWIDTH-1:0] out_res_q;
    logic [6:0]        out_flags_q;

    assign rd_next = rd_ptr_q + 1'b1;
    // First record of a drain comes from rd_ptr; every later one from the entry after it.
    assign rd_sel  = out_valid_q ? rd_next : rd_ptr_q;

    // Next-state, pointer, counter and drain-handshake logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        store       = 1'b0;
        load_out    = 1'b0;
        if (arm_i) begin
            // Arm restarts from any state; it beats a trigger and swallows a same-cycle sample.
            state_d     = StArmed;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StArmed, StPost: begin
                    store = sample_valid_i;
                    if (store) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q != CW'(DEPTH)) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (state_q == StArmed) begin
                        if (trig_i) begin
                            post_d  = PW'(POST_SAMPLES);
                            state_d = (POST_SAMPLES == 0) ? StDrain : StPost;
                        end
                    end else if (store) begin
                        post_d = post_q - 1'b1;
                        if (post_q == PW'(1)) begin
                            state_d = StDrain;
                        end
                    end
                    // Oldest entry; only consumed on the edge that enters DRAIN.
                    rd_ptr_d = wr_ptr_d - count_d[PW-1:0];
                end
                StDrain: begin
                    if (sample_valid_i) begin
                        overflow_d = 1'b1;
                    end
                    if (!out_valid_q) begin
                        if (count_q == '0) begin
                            state_d = StDone;
                        end else begin
                            out_valid_d = 1'b1;
                            load_out    = 1'b1;
                        end
                    end else if (out_ready_i) begin
                        count_d  = count_q - 1'b1;
                        rd_ptr_d = rd_next;
                        if (count_q == CW'(1)) begin
                            out_valid_d = 1'b0;
                            state_d     = StDone;
                        end else begin
                            load_out = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Record storage; no reset needed since count gates what is ever read.
    always_ff @(posedge clk) begin
        if (store) begin
            pc_mem[wr_ptr_q]    <= pc_i;
            res_mem[wr_ptr_q]   <= res_i;
            flags_mem[wr_ptr_q] <= {br_taken_i, rd_we_i, rd_i};
        end
    end

    // Registered drain data; held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pc_q    <= '0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else if (load_out) begin
            out_pc_q    <= pc_mem[rd_sel];
            out_res_q   <= res_mem[rd_sel];
            out_flags_q <= flags_mem[rd_sel];
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] out_ts_q;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];

    // Free-running cycle counter, restarted by arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else if (arm_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Timestamp storage alongside each captured record.
    always_ff @(posedge clk) begin
        if (store) begin
            ts_mem[wr_ptr_q] <= ts_q;
        end
    end

    // Registered drained timestamp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ts_q <= '0;
        end else if (load_out) begin
            out_ts_q <= ts_mem[rd_sel];
        end
    end

    assign out_ts_o = out_ts_q;
`else
    assign out_ts_o = '0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_pc_o    = out_pc_q;
    assign out_res_o   = out_res_q;
    assign out_flags_o = out_flags_q;
    assign state_o     = state_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

endmodule
